// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target receiver: one-hot state encoding,
// ACK/NACK bus levels and the default target address.
package i2c_pkg;

  localparam logic [6:0] S_IDLE     = 7'b0000001;
  localparam logic [6:0] S_ADDR     = 7'b0000010;
  localparam logic [6:0] S_ADDR_ACK = 7'b0000100;
  localparam logic [6:0] S_RX_DATA  = 7'b0001000;
  localparam logic [6:0] S_DATA_ACK = 7'b0010000;
  localparam logic [6:0] S_TX_DATA  = 7'b0100000;
  localparam logic [6:0] S_IGNORE   = 7'b1000000;

  typedef enum logic [6:0] {
    IDLE     = S_IDLE,
    ADDR     = S_ADDR,
    ADDR_ACK = S_ADDR_ACK,
    RX_DATA  = S_RX_DATA,
    DATA_ACK = S_DATA_ACK,
    TX_DATA  = S_TX_DATA,
    IGNORE   = S_IGNORE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] TARGET_ADDR_DEFAULT = 7'h27;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA pins and derives edge events plus START/STOP
// conditions (SDA moving while SCL is high).
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_s,
  output logic o_sda_s,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_cond,
  output logic o_stop_cond
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl        = r_scl_sync[SYNC_STAGES-1];
  assign w_sda        = r_sda_sync[SYNC_STAGES-1];
  assign o_scl_s      = w_scl;
  assign o_sda_s      = w_sda;
  assign o_scl_rise   = w_scl & ~r_scl_d;
  assign o_scl_fall   = ~w_scl & r_scl_d;
  assign o_start_cond = ~w_sda & r_sda_d & w_scl;
  assign o_stop_cond  = w_sda & ~r_sda_d & w_scl;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver: address match, ACK generation and write-byte capture.
// Read-data support is enabled by defining I2C_TARGET_READ_EN.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving address ACK for one SCL low-high-low period
// RX_DATA  | shifting in a write-data byte
// DATA_ACK | driving (or withholding) data ACK
// TX_DATA  | driving read data, then sampling master ACK
// IGNORE   | not addressed, wait for START/STOP
import i2c_pkg::*;

module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = TARGET_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  input  logic [7:0] tx_data,
  output logic       tx_load
);

`ifdef I2C_TARGET_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic w_scl_s_unused, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_addr_match;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:1] r_shift;
  logic       r_phase;
  logic       r_first;
  logic       r_ack_ok;
  logic       r_sda_oe, r_busy, r_rx_valid, r_rx_first, r_start_det, r_stop_det;
  logic [7:0] r_rx_data;
`ifdef I2C_TARGET_READ_EN
  logic       r_rw, r_tx_load, r_tx_pend, r_tx_ack, r_tx_wait;
  logic [7:0] r_tx_shift;
`else
  logic       w_tx_unused;
  assign w_tx_unused = ^tx_data;
`endif

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_scl        (scl_in),
    .i_sda        (sda_in),
    .o_scl_s      (w_scl_s_unused),
    .o_sda_s      (w_sda_s),
    .o_scl_rise   (w_scl_rise),
    .o_scl_fall   (w_scl_fall),
    .o_start_cond (w_start),
    .o_stop_cond  (w_stop)
  );

  // General call (7'h00) is never answered, even if TARGET_ADDR is zero.
  assign w_addr_match = (r_shift == TARGET_ADDR) && (r_shift != 7'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd7;
      r_shift     <= '0;
      r_phase     <= 1'b0;
      r_first     <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_rx_data   <= '0;
`ifdef I2C_TARGET_READ_EN
      r_rw        <= 1'b0;
      r_tx_load   <= 1'b0;
      r_tx_pend   <= 1'b0;
      r_tx_ack    <= 1'b0;
      r_tx_wait   <= 1'b0;
      r_tx_shift  <= '0;
`endif
    end else begin
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      r_tx_load   <= 1'b0;
`endif
      if (w_start) begin
        r_state     <= ADDR;
        r_bit_cnt   <= 3'd7;
        r_shift     <= '0;
        r_phase     <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_start_det <= 1'b1;
      end else if (w_stop) begin
        r_state    <= IDLE;
        r_phase    <= 1'b0;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_stop_det <= 1'b1;
      end else begin
        case (r_state)
          IDLE: ;
          ADDR: if (w_scl_rise) begin
            r_bit_cnt <= r_bit_cnt - 3'd1;
            if (r_bit_cnt != 3'd0) begin
              r_shift[r_bit_cnt] <= w_sda_s;
            end else if (w_addr_match && (!w_sda_s || READ_EN)) begin
              r_state <= ADDR_ACK;
              r_phase <= 1'b0;
`ifdef I2C_TARGET_READ_EN
              r_rw    <= w_sda_s;
`endif
            end else begin
              r_state <= IGNORE;
              r_busy  <= 1'b0;
            end
          end
          ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_oe <= 1'b1;
              r_busy   <= 1'b1;
              r_phase  <= 1'b1;
            end else begin
              r_sda_oe <= 1'b0;
              r_phase  <= 1'b0;
              r_first  <= 1'b1;
              r_state  <= RX_DATA;
`ifdef I2C_TARGET_READ_EN
              if (r_rw) begin
                r_state   <= TX_DATA;
                r_tx_load <= 1'b1;
                r_tx_pend <= 1'b1;
                r_tx_ack  <= 1'b0;
                r_tx_wait <= 1'b0;
              end
`endif
            end
          end
          RX_DATA: if (w_scl_rise) begin
            r_bit_cnt <= r_bit_cnt - 3'd1;
            if (r_bit_cnt != 3'd0) begin
              r_shift[r_bit_cnt] <= w_sda_s;
            end else begin
              r_rx_data  <= {r_shift, w_sda_s};
              r_rx_valid <= rx_ready;
              r_rx_first <= r_first & rx_ready;
              r_first    <= 1'b0;
              r_ack_ok   <= rx_ready;
              r_phase    <= 1'b0;
              r_state    <= DATA_ACK;
            end
          end
          DATA_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_oe <= r_ack_ok;
              r_phase  <= 1'b1;
            end else begin
              r_sda_oe <= 1'b0;
              r_phase  <= 1'b0;
              r_state  <= RX_DATA;
            end
          end
`ifdef I2C_TARGET_READ_EN
          // tx_data arrives the clk after tx_load; first byte is driven at once
          // (SCL already low), later bytes wait for the fall after the ACK bit.
          TX_DATA: if (r_tx_pend) begin
            r_tx_pend  <= 1'b0;
            r_tx_shift <= tx_data;
            if (!r_tx_wait) begin
              r_sda_oe  <= ~tx_data[7];
              r_bit_cnt <= 3'd7;
            end
          end else if (r_tx_ack) begin
            if (w_scl_rise && !r_tx_wait) begin
              if (w_sda_s == I2C_ACK) begin
                r_tx_load <= 1'b1;
                r_tx_pend <= 1'b1;
                r_tx_wait <= 1'b1;
              end else begin
                r_tx_ack <= 1'b0;
                r_busy   <= 1'b0;
                r_state  <= IGNORE;
              end
            end else if (w_scl_fall && r_tx_wait) begin
              r_sda_oe  <= ~r_tx_shift[7];
              r_bit_cnt <= 3'd7;
              r_tx_ack  <= 1'b0;
              r_tx_wait <= 1'b0;
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 3'd0) begin
              r_sda_oe <= 1'b0;
              r_tx_ack <= 1'b1;
            end else begin
              r_sda_oe  <= ~r_tx_shift[r_bit_cnt - 3'd1];
              r_bit_cnt <= r_bit_cnt - 3'd1;
            end
          end
`endif
          IGNORE: r_sda_oe <= 1'b0;
          default: begin
            r_state  <= IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_first  = r_rx_first;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign busy      = r_busy;
`ifdef I2C_TARGET_READ_EN
  assign tx_load   = r_tx_load;
`else
  assign tx_load   = 1'b0;
`endif

endmodule
